// File: rtl/puf_crp_ctrl.sv
// Challenge-response sequencer for a parallel arbiter PUF array.
// Fires NEVAL evaluations per challenge and emits majority-voted CRPs.
module puf_crp_ctrl #(
  parameter int CW         = 16,
  parameter int RW         = 16,
  parameter int PULSE_CYC  = 4,
  parameter int SETTLE_CYC = 8,
  parameter int NEVAL      = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [CW-1:0] seed,
  input  logic [7:0]    num_crp,
  output logic          busy,
  output logic [CW-1:0] challenge,
  output logic          pulse,
  input  logic [RW-1:0] response_in,
  output logic          crp_valid,
  input  logic          crp_ready,
  output logic [CW-1:0] crp_challenge,
  output logic [RW-1:0] crp_response,
  output logic [RW-1:0] unstable_mask,
  output logic          done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PULSE,
    S_SETTLE,
    S_SAMPLE,
    S_VOTE,
    S_OUT,
    S_DONE
  } state_t;

  localparam logic [7:0] PULSE_LAST  = 8'(PULSE_CYC - 1);
  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYC - 1);
  localparam logic [3:0] EVAL_LAST   = 4'(NEVAL - 1);
  localparam logic [3:0] HALF        = 4'(NEVAL / 2);
  localparam logic [3:0] ALL         = 4'(NEVAL);
  localparam logic [CW-1:0] SEED_ALT = CW'(16'hACE1);

  state_t          state_q;
  logic [7:0]      cnt_q;
  logic [3:0]      eval_q;
  logic [7:0]      remaining_q;
  logic [3:0]      ones_q [RW];
  logic            busy_q;
  logic [CW-1:0]   chal_q;
  logic            pulse_q;
  logic            valid_q;
  logic [CW-1:0]   crp_chal_q;
  logic [RW-1:0]   crp_resp_q;
  logic [RW-1:0]   unst_q;
  logic            done_q;

  logic [RW-1:0]   vote_resp_d;
  logic [RW-1:0]   vote_unst_d;

  // Fibonacci LFSR, x^16+x^14+x^13+x^11+1
  function automatic logic [CW-1:0] lfsr_next(input logic [CW-1:0] s);
    return {s[CW-2:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  // Per-bit majority and disagreement from the accumulated ones counts
  always_comb begin
    vote_resp_d = '0;
    vote_unst_d = '0;
    for (int i = 0; i < RW; i++) begin
      vote_resp_d[i] = ones_q[i] > HALF;
      vote_unst_d[i] = (ones_q[i] != 4'd0) && (ones_q[i] != ALL);
    end
  end

  // Sequencer FSM with registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      eval_q      <= '0;
      remaining_q <= '0;
      for (int i = 0; i < RW; i++) ones_q[i] <= '0;
      busy_q      <= 1'b0;
      chal_q      <= '0;
      pulse_q     <= 1'b0;
      valid_q     <= 1'b0;
      crp_chal_q  <= '0;
      crp_resp_q  <= '0;
      unst_q      <= '0;
      done_q      <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            chal_q      <= (seed == '0) ? SEED_ALT : seed;
            remaining_q <= num_crp;
            eval_q      <= '0;
            cnt_q       <= '0;
            for (int i = 0; i < RW; i++) ones_q[i] <= '0;
            busy_q      <= 1'b1;
            if (num_crp == 8'd0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_PULSE;
              pulse_q <= 1'b1;
            end
          end
        end
        S_PULSE: begin
          if (cnt_q == PULSE_LAST) begin
            cnt_q   <= '0;
            pulse_q <= 1'b0;
            state_q <= S_SETTLE;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        S_SETTLE: begin
          if (cnt_q == SETTLE_LAST) begin
            cnt_q   <= '0;
            state_q <= S_SAMPLE;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        S_SAMPLE: begin
          for (int i = 0; i < RW; i++)
            ones_q[i] <= ones_q[i] + {3'b000, response_in[i]};
          eval_q <= eval_q + 4'd1;
          if (eval_q == EVAL_LAST) begin
            state_q <= S_VOTE;
          end else begin
            state_q <= S_PULSE;
            pulse_q <= 1'b1;
          end
        end
        S_VOTE: begin
          crp_resp_q <= vote_resp_d;
          unst_q     <= vote_unst_d;
          crp_chal_q <= chal_q;
          valid_q    <= 1'b1;
          state_q    <= S_OUT;
        end
        S_OUT: begin
          if (crp_ready) begin
            valid_q <= 1'b0;
            eval_q  <= '0;
            cnt_q   <= '0;
            for (int i = 0; i < RW; i++) ones_q[i] <= '0;
            if (remaining_q == 8'd1) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              remaining_q <= remaining_q - 8'd1;
              chal_q      <= lfsr_next(chal_q);
              pulse_q     <= 1'b1;
              state_q     <= S_PULSE;
            end
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          pulse_q <= 1'b0;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy          = busy_q;
  assign challenge     = chal_q;
  assign pulse         = pulse_q;
  assign crp_valid     = valid_q;
  assign crp_challenge = crp_chal_q;
  assign crp_response  = crp_resp_q;
  assign unstable_mask = unst_q;
  assign done          = done_q;

endmodule
